// File: rtl/md_scheduler_pkg.sv
// Shared MD-unit definitions: md_op codes, default latencies, result type and op classifiers.
// Latency/backpressure: none (definitions only); madd/msub support is selected by MD_MADD_EN.
package md_scheduler_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MFHI  = 4'd6;
  localparam logic [3:0] MD_MFLO  = 4'd7;
  localparam logic [3:0] MD_MADD  = 4'd8;
  localparam logic [3:0] MD_MADDU = 4'd9;
  localparam logic [3:0] MD_MSUB  = 4'd10;
  localparam logic [3:0] MD_MSUBU = 4'd11;
  localparam logic [3:0] MD_NONE  = 4'd15;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  // Ops that occupy the unit for a counted number of cycles.
  function automatic logic md_is_long(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU:     return 1'b1;
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU:   return MADD_EN;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// E-stage <-> MD unit signal bundle; master is the pipeline side, slave is the MD unit.
// Latency/backpressure: wires only; stall_md is the backpressure towards the D stage.
interface md_scheduler_if;
  logic        Req;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_rd;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output Req, start, md_op, rs_data, rt_data, d_is_md,
    input  busy, stall_md, md_rd, hi, lo
  );

  modport slave (
    input  Req, start, md_op, rs_data, rt_data, d_is_md,
    output busy, stall_md, md_rd, hi, lo
  );
endinterface

// File: rtl/md_scheduler_calc.sv
// Combinational 64-bit {hi,lo} result for an MD op from rs/rt and the current HI/LO.
// Latency: 0 cycles; backpressure: none. Divide by zero returns the current HI/LO unchanged.
module md_scheduler_calc
  import md_scheduler_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output md_res_t     res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};
  assign acc    = {hi, lo};

  always_comb begin
    res.hi = hi;
    res.lo = lo;
    case (md_op)
      MD_MULT:  res = md_res_t'(prod_s);
      MD_MULTU: res = md_res_t'(prod_u);
      MD_DIV: begin
        if (rt != 32'd0) begin
          res.lo = $signed(rs) / $signed(rt);
          res.hi = $signed(rs) % $signed(rt);
        end
      end
      MD_DIVU: begin
        if (rt != 32'd0) begin
          res.lo = rs / rt;
          res.hi = rs % rt;
        end
      end
      MD_MADD:  res = md_res_t'(acc + prod_s);
      MD_MADDU: res = md_res_t'(acc + prod_u);
      MD_MSUB:  res = md_res_t'(acc - prod_s);
      MD_MSUBU: res = md_res_t'(acc - prod_u);
      default: ;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// EX-stage mult/div sequencer owning HI/LO; multi-cycle ops are modelled with a busy countdown.
// Latency: MULT_CYC/DIV_CYC busy cycles; backpressure: stall_md holds D-stage MD ops (madd/msub: MD_MADD_EN).
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input logic           clk,
  input logic           reset,
  md_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(((MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC) + 1);

  logic [CNT_W-1:0] cnt_q;
  md_res_t          hl_q;
  md_res_t          pend_q;
  md_res_t          calc_res;
  logic             busy_w;
  logic             accept;

  md_scheduler_calc u_calc (
    .md_op (bus.md_op),
    .rs    (bus.rs_data),
    .rt    (bus.rt_data),
    .hi    (hl_q.hi),
    .lo    (hl_q.lo),
    .res   (calc_res)
  );

  assign busy_w = (cnt_q != '0);
  assign accept = bus.start & ~bus.Req & ~busy_w & md_is_long(bus.md_op);

  // The result is computed at accept time; the countdown only models when it becomes visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      hl_q   <= '0;
      pend_q <= '0;
    end else if (accept) begin
      cnt_q  <= md_is_div(bus.md_op) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      pend_q <= calc_res;
    end else if (busy_w) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        hl_q <= pend_q;
      end
    end else if (!bus.Req) begin
      if (bus.md_op == MD_MTHI) begin
        hl_q.hi <= bus.rs_data;
      end
      if (bus.md_op == MD_MTLO) begin
        hl_q.lo <= bus.rs_data;
      end
    end
  end

  assign bus.busy     = busy_w;
  assign bus.stall_md = bus.d_is_md & (bus.start | busy_w);
  assign bus.md_rd    = (bus.md_op == MD_MFHI) ? hl_q.hi : hl_q.lo;
  assign bus.hi       = hl_q.hi;
  assign bus.lo       = hl_q.lo;

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: vector table of MD ops plus hand-written hazard/flush/reset sequences.
module tb_md_scheduler;
  import md_scheduler_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_scheduler_if bus ();

  md_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    bus.md_op = MD_MTHI; bus.rs_data = h;
    tick();
    bus.md_op = MD_MTLO; bus.rs_data = l;
    tick();
    bus.md_op = MD_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy !== 1'b0 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.md_op = op; bus.rs_data = rs; bus.rt_data = rt; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.md_op = MD_MFLO;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    exp_t e;
    string nm;
    nm = $sformatf("vec%0d", idx);
    preload(v.pre_hi, v.pre_lo);
    sb.push_back('{v.exp_hi, v.exp_lo, v.cyc});
    issue(v.op, v.rs, v.rt);
    #1;
    chk({nm, "_rd_old_lo"}, bus.md_rd, v.pre_lo);
    wait_idle(n);
    e = sb.pop_front();
    chk({nm, "_busy_cyc"}, 32'(n), 32'(e.cyc));
    chk({nm, "_hi"}, bus.hi, e.hi);
    chk({nm, "_lo"}, bus.lo, e.lo);
    bus.md_op = MD_MFHI;
    #1;
    chk({nm, "_rd_new_hi"}, bus.md_rd, e.hi);
    bus.md_op = MD_NONE;
  endtask

  initial begin
    int n;
    vt.push_back('{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFEB, MC});
    vt.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'd0, 32'd0, 32'h00000001, 32'hFFFFFFFE, MC});
    vt.push_back('{MD_MULT,  32'h00010000, 32'h00010000, 32'd3, 32'd4, 32'h00000001, 32'h00000000, MC});
    vt.push_back('{MD_DIVU,  32'd100,      32'd7,        32'd0, 32'd0, 32'd2,        32'd14,       DC});
    vt.push_back('{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC});
    vt.push_back('{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd0, 32'd0, 32'd1,        32'hFFFFFFFD, DC});
    vt.push_back('{MD_DIVU,  32'hFFFFFFFF, 32'd16,       32'd0, 32'd0, 32'd15,       32'h0FFFFFFF, DC});
    vt.push_back('{MD_DIV,   32'd123,      32'd0,        32'd5, 32'd9, 32'd5,        32'd9,        DC});
`ifdef MD_MADD_EN
    vt.push_back('{MD_MADD,  32'd2,        32'd3,        32'd0, 32'd10, 32'd0,       32'd16,       MC});
    vt.push_back('{MD_MSUB,  32'd1,        32'd1,        32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, MC});
    vt.push_back('{MD_MADDU, 32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, MC});
    vt.push_back('{MD_MSUBU, 32'hFFFFFFFF, 32'd2,        32'd2, 32'd0, 32'd0,        32'd2,        MC});
`endif

    bus.Req = 1'b0; bus.start = 1'b0; bus.md_op = MD_NONE;
    bus.rs_data = '0; bus.rt_data = '0; bus.d_is_md = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    bus.d_is_md = 1'b1;
    #1;
    chk("rst_stall_idle", 32'(bus.stall_md), 32'd0);
    bus.start = 1'b1;
    #1;
    chk("rst_stall_start", 32'(bus.stall_md), 32'd1);
    bus.start = 1'b0; bus.d_is_md = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      run_vec(vt[i], i);
    end

    // D-stage MD op stalls across the whole busy window, released right after.
    preload(32'd0, 32'd0);
    bus.d_is_md = 1'b1;
    bus.md_op = MD_MULT; bus.rs_data = 32'd2; bus.rt_data = 32'd3; bus.start = 1'b1;
    #1;
    chk("stall_at_accept", 32'(bus.stall_md), 32'd1);
    tick();
    bus.start = 1'b0; bus.md_op = MD_MFLO;
    for (int i = 0; i < MC; i++) begin
      chk($sformatf("stall_busy%0d", i), 32'(bus.stall_md), 32'd1);
      tick();
    end
    chk("stall_released", 32'(bus.stall_md), 32'd0);
    chk("stall_busy_done", 32'(bus.busy), 32'd0);
    chk("stall_lo", bus.lo, 32'd6);
    bus.d_is_md = 1'b0;

    // Flush on the accept cycle kills the op; flush also blocks mthi.
    preload(32'hA, 32'hB);
    bus.Req = 1'b1;
    bus.md_op = MD_MULT; bus.rs_data = 32'd2; bus.rt_data = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("req_start_busy", 32'(bus.busy), 32'd0);
    bus.md_op = MD_MTHI; bus.rs_data = 32'h55;
    tick();
    bus.md_op = MD_NONE; bus.Req = 1'b0;
    chk("req_start_hi", bus.hi, 32'hA);
    chk("req_start_lo", bus.lo, 32'hB);

    // Flush while busy does not disturb the older running op; start while busy is ignored.
    issue(MD_MULT, 32'd2, 32'd3);
    bus.Req = 1'b1;
    tick();
    bus.Req = 1'b0;
    bus.md_op = MD_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7; bus.start = 1'b1;
    wait_idle(n);
    bus.start = 1'b0; bus.md_op = MD_NONE;
    chk("req_busy_cyc", 32'(n + 1), 32'(MC));
    chk("req_busy_hi", bus.hi, 32'd0);
    chk("req_busy_lo", bus.lo, 32'd6);

`ifndef MD_MADD_EN
    preload(32'h11, 32'h22);
    issue(MD_MADD, 32'd2, 32'd3);
    chk("madd_off_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("madd_off_hi", bus.hi, 32'h11);
    chk("madd_off_lo", bus.lo, 32'h22);
`endif

    // Reset on the third busy cycle discards the pending result.
    preload(32'd5, 32'd9);
    issue(MD_DIVU, 32'd100, 32'd7);
    tick();
    tick();
    chk("rstbusy_still_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstbusy_busy", 32'(bus.busy), 32'd0);
    chk("rstbusy_hi", bus.hi, 32'd0);
    chk("rstbusy_lo", bus.lo, 32'd0);
    repeat (DC + 2) tick();
    chk("rstbusy_late_hi", bus.hi, 32'd0);
    chk("rstbusy_late_lo", bus.lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
